// File: rtl/imm_pkg.sv
// imm_pkg: shared encodings for the immediate generators.
// Holds the format code returned alongside every immediate and the
// RV32/RV64 base opcodes that select an immediate layout.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational immediate decoder, shared by the pipelined
// and single-cycle immediate generators.
// Ports:
//   inst    - 32-bit instruction word
//   imm     - immediate, sign-extended to XLEN (zero-extended for Z)
//   fmt     - format code (imm_pkg::fmt_e encoding)
//   illegal - opcode not recognised (imm forced to 0)
//   pc_rel  - immediate is a PC offset (B, J, AUIPC)
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic            pc_rel
);

    fmt_e        f;
    logic [31:0] raw;

    always_comb begin
        f = FMT_NONE;
        case (inst[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: f = FMT_I;
            OPC_STORE:                     f = FMT_S;
            OPC_BRANCH:                    f = FMT_B;
            OPC_LUI, OPC_AUIPC:            f = FMT_U;
            OPC_JAL:                       f = FMT_J;
            OPC_SYSTEM:                    f = (EN_ZIMM && inst[14]) ? FMT_Z : FMT_I;
            default:                       f = FMT_NONE;
        endcase
    end

    // Every layout is first assembled as a 32-bit sign-extended value; only Z
    // carries a zero top bit, so one final sign extension covers XLEN=64.
    always_comb begin
        raw = '0;
        case (f)
            FMT_I:   raw = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   raw = {inst[31:12], 12'b0};
            FMT_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_Z:   raw = {27'b0, inst[19:15]};
            default: raw = '0;
        endcase
    end

    assign imm     = XLEN'($signed(raw));
    assign fmt     = f;
    assign illegal = (f == FMT_NONE);
    assign pc_rel  = (f == FMT_B) || (f == FMT_J) || (f == FMT_U && inst[6:0] == OPC_AUIPC);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator between fetch and ID/EX, with a
// registered valid/ready output stage backed by a 2-entry skid buffer.
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   in_valid / in_ready - instruction handshake (in_ready is a flop)
//   inst                - 32-bit instruction word
//   out_valid/out_ready - result handshake
//   imm, fmt, illegal, pc_rel - registered decode of the oldest held word
//   imm_cnt             - saturating count of transferred legal results
//   cnt_clr             - synchronous clear of imm_cnt, wins over increment
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic             pc_rel,
    output logic [CNT_W-1:0] imm_cnt,
    input  logic             cnt_clr
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic            pc_rel;
    } word_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic            dec_pc;
    word_t           dec_w;

    word_t           main_q, main_d, skid_q, skid_d;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic            in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            accept, xfer;

    imm_decode_comb #(
        .XLEN    (XLEN),
        .EN_ZIMM (EN_ZIMM)
    ) u_dec (
        .inst    (inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill),
        .pc_rel  (dec_pc)
    );

    assign dec_w = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_ill, pc_rel: dec_pc};

    always_comb begin
        accept   = in_valid && in_ready_q;
        xfer     = main_v_q && out_ready;
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        // Main reloads whenever it is empty or draining; the skid word is older
        // than anything on the input, so it always goes first.
        if (!main_v_q || xfer) begin
            main_v_d = skid_v_q || accept;
            main_d   = skid_v_q ? skid_q : (accept ? dec_w : main_q);
        end
        // Accept is only possible with skid empty, so skid either drains into
        // main or catches a word that arrives while main is stalled.
        if (skid_v_q) begin
            if (xfer) skid_v_d = 1'b0;
        end else if (accept && main_v_q && !xfer) begin
            skid_v_d = 1'b1;
            skid_d   = dec_w;
        end
        in_ready_d = !skid_v_d;
        cnt_d = cnt_clr ? '0
              : (xfer && !main_q.illegal && cnt_q != '1) ? cnt_q + CNT_W'(1)
              : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q   <= 1'b0;
            main_q     <= '0;
            skid_v_q   <= 1'b0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            main_v_q   <= main_v_d;
            main_q     <= main_d;
            skid_v_q   <= skid_v_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign imm       = main_q.imm;
    assign fmt       = main_q.fmt;
    assign illegal   = main_q.illegal;
    assign pc_rel    = main_q.pc_rel;
    assign imm_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven scoreboard bench for imm_gen_pipe, running an
// XLEN=32/CNT_W=16 instance and an XLEN=64/CNT_W=3 instance in lockstep.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic        pcrel;
    } vec_t;

    logic        clk, rst_n, in_valid, out_ready, cnt_clr;
    logic [31:0] inst;

    logic        a_ir, a_ov, a_ill, a_pc;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic [15:0] a_cnt;

    logic        b_ir, b_ov, b_ill, b_pc;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [2:0]  b_cnt;

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[15];
    vec_t cur;
    vec_t q32[$];
    vec_t q64[$];
    logic [15:0] m32;
    logic [2:0]  m64;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16), .EN_ZIMM(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir), .inst(inst),
        .out_valid(a_ov), .out_ready(out_ready), .imm(a_imm), .fmt(a_fmt),
        .illegal(a_ill), .pc_rel(a_pc), .imm_cnt(a_cnt), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(3), .EN_ZIMM(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir), .inst(inst),
        .out_valid(b_ov), .out_ready(out_ready), .imm(b_imm), .fmt(b_fmt),
        .illegal(b_ill), .pc_rel(b_pc), .imm_cnt(b_cnt), .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboards: each queue models the words held by one DUT. Outputs are
    // compared against the head every cycle they are valid (so a stall must
    // hold them), and popped on transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            m32 = '0;
        end else begin
            int sz;
            sz = q32.size();
            chk("cnt32", 64'(a_cnt), 64'(m32));
            chk("valid32", 64'(a_ov), 64'(sz != 0));
            chk("ready32", 64'(a_ir), 64'(sz < 2));
            if (a_ov && sz > 0) begin
                chk("imm32", 64'(a_imm), 64'(q32[0].imm[31:0]));
                chk("fmt32", 64'(a_fmt), 64'(q32[0].fmt));
                chk("ill32", 64'(a_ill), 64'(q32[0].ill));
                chk("pcrel32", 64'(a_pc), 64'(q32[0].pcrel));
                if (out_ready) begin
                    if (!q32[0].ill && m32 != 16'hFFFF) m32 = m32 + 16'd1;
                    void'(q32.pop_front());
                end
            end
            if (cnt_clr) m32 = '0;
            if (in_valid && sz < 2) q32.push_back(cur);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q64.delete();
            m64 = '0;
        end else begin
            int sz;
            sz = q64.size();
            chk("cnt64", 64'(b_cnt), 64'(m64));
            chk("valid64", 64'(b_ov), 64'(sz != 0));
            chk("ready64", 64'(b_ir), 64'(sz < 2));
            if (b_ov && sz > 0) begin
                chk("imm64", b_imm, q64[0].imm);
                chk("fmt64", 64'(b_fmt), 64'(q64[0].fmt));
                chk("ill64", 64'(b_ill), 64'(q64[0].ill));
                chk("pcrel64", 64'(b_pc), 64'(q64[0].pcrel));
                if (out_ready) begin
                    if (!q64[0].ill && m64 != 3'b111) m64 = m64 + 3'd1;
                    void'(q64.pop_front());
                end
            end
            if (cnt_clr) m64 = '0;
            if (in_valid && sz < 2) q64.push_back(cur);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present table entry i until it is accepted; returns 1 time unit after
    // the accepting edge with in_valid still high.
    task automatic send(input int i);
        bit acc;
        inst     = tbl[i].inst;
        cur      = tbl[i];
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            acc = a_ir;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: entry %0d not accepted within 20 cycles", i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 1'b0};
        tbl[1]  = '{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0, 1'b0};
        tbl[2]  = '{32'h00000863, 64'h00000000_00000010, 3'd3, 1'b0, 1'b1};
        tbl[3]  = '{32'h123452B7, 64'h00000000_12345000, 3'd4, 1'b0, 1'b0};
        tbl[4]  = '{32'hFF9FF06F, 64'hFFFFFFFF_FFFFFFF8, 3'd5, 1'b0, 1'b1};
        tbl[5]  = '{32'h340FD073, 64'h00000000_0000001F, 3'd6, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000007F, 64'h00000000_00000000, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{32'h00001017, 64'h00000000_00001000, 3'd4, 1'b0, 1'b1};
        tbl[8]  = '{32'hFFFFF297, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0, 1'b1};
        tbl[9]  = '{32'h80002003, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{32'h00008067, 64'h00000000_00000000, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{32'h34011073, 64'h00000000_00000340, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0, 1'b1};
        tbl[13] = '{32'h0010006F, 64'h00000000_00000800, 3'd5, 1'b0, 1'b1};
        tbl[14] = '{32'h00000033, 64'h00000000_00000000, 3'd0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; inst = '0;
        cur = tbl[0];
        tick(2);
        chk("rst_ov32", 64'(a_ov), 64'd0);
        chk("rst_ir32", 64'(a_ir), 64'd1);
        chk("rst_imm32", 64'(a_imm), 64'd0);
        chk("rst_fmt32", 64'(a_fmt), 64'd0);
        chk("rst_ill32", 64'(a_ill), 64'd0);
        chk("rst_pc32", 64'(a_pc), 64'd0);
        chk("rst_cnt32", 64'(a_cnt), 64'd0);
        chk("rst_ov64", 64'(b_ov), 64'd0);
        chk("rst_ir64", 64'(b_ir), 64'd1);
        chk("rst_imm64", b_imm, 64'd0);
        chk("rst_cnt64", 64'(b_cnt), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single word: one-cycle latency, count after transfer.
        send(0);
        in_valid = 1'b0;
        chk("lat_ov", 64'(a_ov), 64'd1);
        chk("lat_imm", 64'(a_imm), 64'hFFFFFFFF);
        chk("lat_fmt", 64'(a_fmt), 64'd1);
        tick(1);
        chk("lat_cnt", 64'(a_cnt), 64'd1);

        // Whole table back-to-back with out_ready held high.
        for (int i = 0; i < 15; i++) send(i);
        in_valid = 1'b0;
        tick(3);

        // Stall: A, B accepted, C held off while out_ready is low.
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_cnt", 64'(a_cnt), 64'd0);
        out_ready = 1'b0;
        send(1);
        chk("stall_ir_a", 64'(a_ir), 64'd1);
        chk("stall_ov_a", 64'(a_ov), 64'd1);
        send(2);
        chk("stall_ir_b", 64'(a_ir), 64'd0);
        chk("stall_hold_b", 64'(a_imm), 64'hFFFFFFFC);
        inst = tbl[3].inst;
        cur  = tbl[3];
        tick(1);
        chk("stall_hold_c", 64'(a_imm), 64'hFFFFFFFC);
        chk("stall_ir_c", 64'(a_ir), 64'd0);
        out_ready = 1'b1;
        send(3);
        send(4);
        in_valid = 1'b0;
        tick(4);
        chk("stream_cnt", 64'(a_cnt), 64'd4);
        chk("stream_drained", 64'(q32.size()), 64'd0);

        // Reset with both registers full.
        out_ready = 1'b0;
        send(5);
        send(6);
        in_valid = 1'b0;
        chk("full_ir", 64'(a_ir), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ov32", 64'(a_ov), 64'd0);
        chk("arst_ir32", 64'(a_ir), 64'd1);
        chk("arst_ov64", 64'(b_ov), 64'd0);
        chk("arst_ir64", 64'(b_ir), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(7);
        in_valid = 1'b0;
        chk("post_rst_ov", 64'(a_ov), 64'd1);
        chk("post_rst_imm", b_imm, 64'h1000);
        tick(2);

        // Saturation of the 3-bit counter, then clear racing a transfer.
        for (int k = 0; k < 10; k++) send(0);
        in_valid = 1'b0;
        tick(2);
        chk("sat_cnt64", 64'(b_cnt), 64'd7);
        chk("sat_cnt32", 64'(a_cnt), 64'd11);
        cnt_clr = 1'b1;
        send(0);
        in_valid = 1'b0;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_xfer32", 64'(a_cnt), 64'd0);
        chk("clr_xfer64", 64'(b_cnt), 64'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
